// File: rtl/serial_magnitude_compare.sv
// Bit-serial magnitude comparator: scans operands LSB-first, one bit per clock,
// and publishes registered GT/LT/EQ flags through a start/busy/done handshake.
module serial_magnitude_compare #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [CW-1:0]    r_cnt;
   logic             r_g;
   logic             r_l;
   logic             r_busy;
   logic             r_done;
   logic             r_gt;
   logic             r_lt;
   logic             r_eq;

   logic w_ai;
   logic w_bi;
   logic w_msb;
   logic w_swap;
   logic w_g_next;
   logic w_l_next;

   // Running flag update; a later bit overrides, and in signed mode the sign bit votes inverted
   always_comb begin
      w_ai     = r_sa[0];
      w_bi     = r_sb[0];
      w_msb    = (r_cnt == LAST_BIT);
      w_swap   = w_msb & SIGNED;
      w_g_next = r_g;
      w_l_next = r_l;
      if (w_ai & ~w_bi) begin
         w_g_next = ~w_swap;
         w_l_next = w_swap;
      end else if (~w_ai & w_bi) begin
         w_g_next = w_swap;
         w_l_next = ~w_swap;
      end else begin
         w_g_next = r_g;
         w_l_next = r_l;
      end
   end

   // Control FSM, operand shifters and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sa    <= '0;
         r_sb    <= '0;
         r_cnt   <= '0;
         r_g     <= 1'b0;
         r_l     <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_gt    <= 1'b0;
         r_lt    <= 1'b0;
         r_eq    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sa    <= a;
                  r_sb    <= b;
                  r_cnt   <= '0;
                  r_g     <= 1'b0;
                  r_l     <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_g  <= w_g_next;
               r_l  <= w_l_next;
               r_sa <= {1'b0, r_sa[WIDTH-1:1]};
               r_sb <= {1'b0, r_sb[WIDTH-1:1]};
               // Counter stops at the MSB instead of wrapping
               if (w_msb) begin
                  r_gt    <= w_g_next;
                  r_lt    <= w_l_next;
                  r_eq    <= ~w_g_next & ~w_l_next;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign gt   = r_gt;
   assign lt   = r_lt;
   assign eq   = r_eq;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench for serial_magnitude_compare: directed handshake/reset
// scenarios plus randomized compares on 2/32/64-bit, signed and unsigned builds.
module tb_serial_magnitude_compare;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  start_v;
   logic [63:0] a_s [6];
   logic [63:0] b_s [6];
   logic [5:0]  busy_v, done_v, gt_v, lt_v, eq_v;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   function automatic int w_of(input int i);
      case (i)
         0, 1:    return 32;
         2, 3:    return 2;
         default: return 64;
      endcase
   endfunction

   function automatic bit s_of(input int i);
      return (i % 2) == 1;
   endfunction

   // Instances: 0/1 = 32u/32s, 2/3 = 2u/2s, 4/5 = 64u/64s
   for (genvar g = 0; g < 6; g++) begin : g_dut
      serial_magnitude_compare #(.WIDTH(w_of(g)), .SIGNED(s_of(g))) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_v[g]),
         .a     (a_s[g][w_of(g)-1:0]),
         .b     (b_s[g][w_of(g)-1:0]),
         .busy  (busy_v[g]),
         .done  (done_v[g]),
         .gt    (gt_v[g]),
         .lt    (lt_v[g]),
         .eq    (eq_v[g])
      );
   end

   function automatic logic [63:0] mask_of(input int w);
      logic [63:0] m;
      m = '1;
      if (w < 64) m = (64'd1 << w) - 64'd1;
      return m;
   endfunction

   // Reference {gt,lt,eq} from plain integer comparison of the width-limited values
   function automatic logic [2:0] ref_flags(input int idx, input logic [63:0] av, input logic [63:0] bv);
      int          w;
      logic [63:0] ua, ub;
      longint      sa, sb;
      w  = w_of(idx);
      ua = av & mask_of(w);
      ub = bv & mask_of(w);
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
      if (s_of(idx)) return (sa > sb) ? 3'b100 : (sa < sb) ? 3'b010 : 3'b001;
      return (ua > ub) ? 3'b100 : (ua < ub) ? 3'b010 : 3'b001;
   endfunction

   // Single-cycle greater-than: bias the sign bit, then compare unsigned
   function automatic logic par_gt(input int idx, input logic [63:0] av, input logic [63:0] bv);
      int          w;
      logic [63:0] bias;
      w    = w_of(idx);
      bias = s_of(idx) ? (64'd1 << (w - 1)) : 64'd0;
      return ((av & mask_of(w)) ^ bias) > ((bv & mask_of(w)) ^ bias);
   endfunction

   task automatic do_cmp(input int idx, input logic [63:0] av, input logic [63:0] bv, input int poke,
                         output logic [2:0] flags, output int lat, output int busy_bad,
                         output logic post_done, output logic post_busy);
      @(negedge clk);
      a_s[idx] = av;
      b_s[idx] = bv;
      start_v[idx] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[idx] = 1'b0;
      lat = -1;
      busy_bad = 0;
      flags = 3'b000;
      for (int c = 1; c <= 200; c++) begin
         if (!busy_v[idx]) busy_bad++;
         if (done_v[idx]) begin
            lat   = c;
            flags = {gt_v[idx], lt_v[idx], eq_v[idx]};
            break;
         end
         if (c == poke) begin
            a_s[idx] = {$urandom, $urandom};
            b_s[idx] = {$urandom, $urandom};
            start_v[idx] = 1'b1;
         end else begin
            start_v[idx] = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end
      start_v[idx] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      post_done = done_v[idx];
      post_busy = busy_v[idx];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_v = 6'b0;
      for (int i = 0; i < 6; i++) begin
         a_s[i] = 64'd0;
         b_s[i] = 64'd0;
      end
      #12;
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if ({busy_v[i], done_v[i], gt_v[i], lt_v[i], eq_v[i]} !== 5'b00000)
            $display("FAIL reset_outs[%0d]: got %b want 00000", i,
                     {busy_v[i], done_v[i], gt_v[i], lt_v[i], eq_v[i]});
         else pass_cnt++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned_priority();
      logic [2:0] fl; int lat, bb; logic pd, pb;
      do_cmp(0, 64'h0000_0001, 64'h0000_0002, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (lat !== 33) $display("FAIL up_latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if (fl !== 3'b010) $display("FAIL up_lt flags: got %b want 010", fl); else pass_cnt++;
      total_cnt++; if ({pd, pb} !== 2'b00) $display("FAIL up_after_done done,busy: got %b want 00", {pd, pb}); else pass_cnt++;
      do_cmp(0, 64'h8000_0000, 64'h7FFF_FFFF, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b100) $display("FAIL up_msb_gt flags: got %b want 100", fl); else pass_cnt++;
   endtask

   task automatic test_equality();
      logic [2:0] fl; int lat, bb; logic pd, pb;
      do_cmp(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b001) $display("FAIL eq_ones flags: got %b want 001", fl); else pass_cnt++;
      total_cnt++; if (bb !== 0) $display("FAIL eq_busy_low cycles: got %0d want 0", bb); else pass_cnt++;
      do_cmp(0, 64'h0, 64'h0, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b001) $display("FAIL eq_zero flags: got %b want 001", fl); else pass_cnt++;
      do_cmp(0, 64'hFFFF_FFFF, 64'h0, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b100) $display("FAIL max_vs_zero flags: got %b want 100", fl); else pass_cnt++;
      total_cnt++; if (bb !== 0) $display("FAIL max_busy_low cycles: got %0d want 0", bb); else pass_cnt++;
   endtask

   task automatic test_signed();
      logic [2:0] fl; int lat, bb; logic pd, pb;
      do_cmp(1, 64'hFFFF_FFFF, 64'h0000_0001, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b010) $display("FAIL s_neg1_vs_1 flags: got %b want 010", fl); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL s_latency: got %0d want 33", lat); else pass_cnt++;
      do_cmp(1, 64'h7FFF_FFFF, 64'h8000_0000, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b100) $display("FAIL s_max_vs_min flags: got %b want 100", fl); else pass_cnt++;
      do_cmp(1, 64'h8000_0000, 64'h8000_0001, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b010) $display("FAIL s_min_vs_min1 flags: got %b want 010", fl); else pass_cnt++;
   endtask

   task automatic test_handshake();
      logic [2:0] fl; int lat, bb; logic pd, pb;
      // Restart request plus operand change five cycles into RUN
      do_cmp(0, 64'd10, 64'd20, 5, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b010) $display("FAIL hs_ignore flags: got %b want 010", fl); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL hs_latency: got %0d want 33", lat); else pass_cnt++;
      total_cnt++; if ({pd, pb} !== 2'b00) $display("FAIL hs_no_requeue done,busy: got %b want 00", {pd, pb}); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int rise [4];
      int n = 0, wide = 0, badres = 0;
      logic prev = 1'b0;
      @(negedge clk);
      a_s[0] = 64'd5;
      b_s[0] = 64'd9;
      start_v[0] = 1'b1;
      for (int c = 0; c < 120; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_v[0] && !prev && n < 4) begin
            rise[n] = c;
            n++;
         end
         if (done_v[0] && prev) wide++;
         if (done_v[0] && {gt_v[0], lt_v[0], eq_v[0]} !== 3'b010) badres++;
         prev = done_v[0];
      end
      start_v[0] = 1'b0;
      repeat (40) @(negedge clk);
      total_cnt++; if (n !== 3) $display("FAIL b2b_pulse_count: got %0d want 3", n); else pass_cnt++;
      total_cnt++; if (n >= 2 && rise[1] - rise[0] !== 34) $display("FAIL b2b_period1: got %0d want 34", rise[1] - rise[0]); else if (n >= 2) pass_cnt++; else $display("FAIL b2b_period1: got no second pulse want 34");
      total_cnt++; if (n >= 3 && rise[2] - rise[1] !== 34) $display("FAIL b2b_period2: got %0d want 34", rise[2] - rise[1]); else if (n >= 3) pass_cnt++; else $display("FAIL b2b_period2: got no third pulse want 34");
      total_cnt++; if (wide !== 0) $display("FAIL b2b_pulse_width extra cycles: got %0d want 0", wide); else pass_cnt++;
      total_cnt++; if (badres !== 0) $display("FAIL b2b_result bad pulses: got %0d want 0", badres); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      logic [2:0] fl; int lat, bb; logic pd, pb;
      int dcnt = 0;
      @(negedge clk);
      a_s[0] = 64'd7;
      b_s[0] = 64'd3;
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]} !== 5'b00000)
         $display("FAIL rst_mid_run outs: got %b want 00000", {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]});
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done_v[0]) dcnt++;
      end
      total_cnt++; if (dcnt !== 0) $display("FAIL rst_no_done pulses: got %0d want 0", dcnt); else pass_cnt++;
      do_cmp(0, 64'd3, 64'd3, -1, fl, lat, bb, pd, pb);
      total_cnt++; if (fl !== 3'b001) $display("FAIL rst_then_eq flags: got %b want 001", fl); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL rst_then_latency: got %0d want 33", lat); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [2:0] fl, want; int lat, bb; logic pd, pb;
      logic [63:0] av, bv;
      for (int idx = 0; idx < 6; idx++) begin
         for (int n = 0; n < 150; n++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) bv = av;
            else if ($urandom_range(0, 7) == 0) bv = av ^ (64'd1 << $urandom_range(0, w_of(idx) - 1));
            want = ref_flags(idx, av, bv);
            do_cmp(idx, av, bv, ($urandom_range(0, 1) == 1) ? 1 : -1, fl, lat, bb, pd, pb);
            total_cnt++;
            if (fl !== want)
               $display("FAIL rand_flags[%0d] a=%h b=%h: got %b want %b", idx, av, bv, fl, want);
            else pass_cnt++;
            total_cnt++;
            if (fl[2] !== par_gt(idx, av, bv))
               $display("FAIL rand_par_gt[%0d] a=%h b=%h: got %b want %b", idx, av, bv, fl[2], par_gt(idx, av, bv));
            else pass_cnt++;
            total_cnt++;
            if (lat !== w_of(idx) + 1)
               $display("FAIL rand_latency[%0d]: got %0d want %0d", idx, lat, w_of(idx) + 1);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_priority();
      test_equality();
      test_signed();
      test_handshake();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
